// File: rtl/matmul_sequencer.sv
// Sequences a signed matrix multiply C = A*B over flat-indexed operand/result ports.
// Fixed latency 2 + h_a*w_b*(w_a+2) cycles from start to done; start is ignored while busy.
module matmul_sequencer #(
   parameter int DW     = 16,
   parameter int DIM_BW = 5,
   parameter int AW     = 2*DIM_BW
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 start_i,
   input  logic [7:0]           op_i,
   input  logic [DIM_BW-1:0]    w_a_i,
   input  logic [DIM_BW-1:0]    h_a_i,
   input  logic [DIM_BW-1:0]    w_b_i,
   input  logic [DIM_BW-1:0]    h_b_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 rd_en_o,
   output logic [AW-1:0]        a_addr_o,
   output logic [AW-1:0]        b_addr_o,
   input  logic signed [DW-1:0] a_data_i,
   input  logic signed [DW-1:0] b_data_i,
   output logic                 c_we_o,
   output logic [AW-1:0]        c_addr_o,
   output logic signed [DW-1:0] c_data_o
);

   localparam int ACC_W   = 2*DW + DIM_BW;
   localparam int MAX_DIM = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t                    state_q, state_d;
   logic [7:0]                op_q, op_d;
   logic [DIM_BW-1:0]         wa_q, wa_d, ha_q, ha_d, wb_q, wb_d, hb_q, hb_d;
   logic [DIM_BW-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic                      rd_q;
   logic signed [2*DW-1:0]    prod;
   logic                      dims_ok, k_last, j_last, i_last, acc_fits;

   assign prod   = a_data_i * b_data_i;
   assign k_last = (k_q == wa_q - DIM_BW'(1));
   assign j_last = (j_q == wb_q - DIM_BW'(1));
   assign i_last = (i_q == ha_q - DIM_BW'(1));

   assign dims_ok = (op_q == 8'd1)
                 && (wa_q != '0) && (ha_q != '0) && (wb_q != '0) && (hb_q != '0)
                 && (int'(wa_q) <= MAX_DIM) && (int'(ha_q) <= MAX_DIM)
                 && (int'(wb_q) <= MAX_DIM) && (int'(hb_q) <= MAX_DIM)
                 && (wa_q == hb_q);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         wa_q    <= '0;
         ha_q    <= '0;
         wb_q    <= '0;
         hb_q    <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wa_q    <= wa_d;
         ha_q    <= ha_d;
         wb_q    <= wb_d;
         hb_q    <= hb_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         rd_q    <= rd_en_o;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_CHECK;
         S_CHECK: state_d = dims_ok ? S_FETCH : S_ERR;
         S_FETCH: if (k_last) state_d = S_DRAIN;
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: state_d = (i_last && j_last) ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand data lags the read strobe by one cycle, so accumulation follows rd_q.
   always_comb begin
      op_d  = op_q;
      wa_d  = wa_q;
      ha_d  = ha_q;
      wb_d  = wb_q;
      hb_d  = hb_q;
      i_d   = i_q;
      j_d   = j_q;
      k_d   = k_q;
      acc_d = rd_q ? acc_q + ACC_W'(prod) : acc_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d = op_i;
               wa_d = w_a_i;
               ha_d = h_a_i;
               wb_d = w_b_i;
               hb_d = h_b_i;
            end
         end
         S_CHECK: begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            acc_d = '0;
         end
         S_FETCH: k_d = k_q + DIM_BW'(1);
         S_WRITE: begin
            k_d   = '0;
            acc_d = '0;
            if (j_last) begin
               j_d = '0;
               i_d = i_q + DIM_BW'(1);
            end else begin
               j_d = j_q + DIM_BW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy_o  = (state_q != S_IDLE);
      rd_en_o = (state_q == S_FETCH);
      c_we_o  = (state_q == S_WRITE);
      done_o  = (state_q == S_DONE);
      err_o   = (state_q == S_ERR);
   end

   assign a_addr_o = AW'(i_q) * AW'(wa_q) + AW'(k_q);
   assign b_addr_o = AW'(k_q) * AW'(wb_q) + AW'(j_q);
   assign c_addr_o = AW'(i_q) * AW'(wb_q) + AW'(j_q);

   // In range exactly when every bit above the result sign bit matches it.
   assign acc_fits = (&acc_q[ACC_W-1:DW-1]) | ~(|acc_q[ACC_W-1:DW-1]);
   assign c_data_o = acc_fits        ? acc_q[DW-1:0] :
                     acc_q[ACC_W-1]  ? {1'b1, {(DW-1){1'b0}}} :
                                       {1'b0, {(DW-1){1'b1}}};

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: directed and random multiplies against a plain-arithmetic model.
module tb_matmul_sequencer;

   localparam int DW     = 16;
   localparam int DIM_BW = 5;
   localparam int AW     = 2*DIM_BW;

   logic                 wb_clk_i = 1'b0;
   logic                 wb_rst_i;
   logic                 start_i;
   logic [7:0]           op_i;
   logic [DIM_BW-1:0]    w_a_i, h_a_i, w_b_i, h_b_i;
   logic                 busy_o, done_o, err_o, rd_en_o, c_we_o;
   logic [AW-1:0]        a_addr_o, b_addr_o, c_addr_o;
   logic signed [DW-1:0] a_data_i, b_data_i, c_data_o;

   matmul_sequencer #(.DW(DW), .DIM_BW(DIM_BW), .AW(AW)) dut (
      .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i), .start_i (start_i), .op_i (op_i),
      .w_a_i (w_a_i), .h_a_i (h_a_i), .w_b_i (w_b_i), .h_b_i (h_b_i),
      .busy_o (busy_o), .done_o (done_o), .err_o (err_o), .rd_en_o (rd_en_o),
      .a_addr_o (a_addr_o), .b_addr_o (b_addr_o), .a_data_i (a_data_i), .b_data_i (b_data_i),
      .c_we_o (c_we_o), .c_addr_o (c_addr_o), .c_data_o (c_data_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int          mem_a [1024];
   int          mem_b [1024];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        pend = 1'b0;
   logic [AW-1:0] pa = '0, pb = '0;
   int          q_ra[$], q_rb[$], q_wa[$];
   longint      q_wd[$];
   int          done_cyc, err_cyc, multi_hi;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int rnd_elem(input bit big);
      if (big) return int'($urandom_range(65535)) - 32768;
      return int'($urandom_range(40)) - 20;
   endfunction

   task automatic clear_logs();
      q_ra.delete(); q_rb.delete(); q_wa.delete(); q_wd.delete();
      done_cyc = -1; err_cyc = -1; multi_hi = 0;
   endtask

   // One clock: memory answers the previous cycle's read, then outputs are logged.
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
      cyc++;
      a_data_i = pend ? 16'(mem_a[pa]) : 16'($urandom);
      b_data_i = pend ? 16'(mem_b[pb]) : 16'($urandom);
      pend = rd_en_o; pa = a_addr_o; pb = b_addr_o;
      if (rd_en_o) begin q_ra.push_back(int'(a_addr_o)); q_rb.push_back(int'(b_addr_o)); end
      if (c_we_o) begin q_wa.push_back(int'(c_addr_o)); q_wd.push_back(longint'(c_data_o)); end
      if (done_o) done_cyc = cyc;
      if (err_o)  err_cyc = cyc;
      if (int'(rd_en_o) + int'(c_we_o) + int'(done_o) + int'(err_o) > 1) multi_hi++;
   endtask

   task automatic fill(input int ha, input int wa, input int wb, input bit big);
      for (int n = 0; n < ha*wa; n++) mem_a[n] = rnd_elem(big);
      for (int n = 0; n < wa*wb; n++) mem_b[n] = rnd_elem(big);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, " busy"}, busy_o, 0);
      chk({tag, " done"}, done_o, 0);
      chk({tag, " err"}, err_o, 0);
      chk({tag, " rd_en"}, rd_en_o, 0);
      chk({tag, " c_we"}, c_we_o, 0);
      chk({tag, " a_addr"}, a_addr_o, 0);
      chk({tag, " b_addr"}, b_addr_o, 0);
      chk({tag, " c_addr"}, c_addr_o, 0);
      chk({tag, " c_data"}, c_data_o, 0);
   endtask

   task automatic run_mm(input string tag, input int op, input int ha, input int wa,
                         input int hb, input int wb, input int restart_at);
      int     start_cyc, budget, n, bad_a, bad_b;
      bit     ok;
      longint s;
      clear_logs();
      op_i = 8'(op); h_a_i = 5'(ha); w_a_i = 5'(wa); h_b_i = 5'(hb); w_b_i = 5'(wb);
      start_i = 1'b1;
      start_cyc = cyc;
      tick();
      start_i = 1'b0;
      op_i = 8'($urandom); h_a_i = 5'($urandom); w_a_i = 5'($urandom);
      h_b_i = 5'($urandom); w_b_i = 5'($urandom);
      budget = 0;
      while (done_cyc < 0 && err_cyc < 0 && budget < 6000) begin
         if (restart_at > 0 && budget == restart_at) start_i = 1'b1;
         tick();
         start_i = 1'b0;
         budget++;
      end
      tick();
      chk({tag, " busy after end"}, busy_o, 0);
      ok = (op == 1) && ha >= 1 && ha <= 16 && wa >= 1 && wa <= 16
           && hb >= 1 && hb <= 16 && wb >= 1 && wb <= 16 && wa == hb;
      if (ok) begin
         chk({tag, " done latency"}, done_cyc - start_cyc, 2 + ha*wb*(wa+2));
         chk({tag, " no err"}, err_cyc, -1);
         chk({tag, " write count"}, q_wa.size(), ha*wb);
         chk({tag, " read count"}, q_ra.size(), ha*wb*wa);
         n = 0; bad_a = 0; bad_b = 0;
         for (int i = 0; i < ha; i++) begin
            for (int j = 0; j < wb; j++) begin
               s = 0;
               for (int k = 0; k < wa; k++) begin
                  s += longint'(mem_a[i*wa+k]) * longint'(mem_b[k*wb+j]);
                  if ((n*wa+k) < q_ra.size()) begin
                     if (q_ra[n*wa+k] != i*wa+k) bad_a++;
                     if (q_rb[n*wa+k] != k*wb+j) bad_b++;
                  end
               end
               if (n < q_wa.size()) begin
                  chk($sformatf("%s c_addr[%0d]", tag, n), q_wa[n], i*wb+j);
                  chk($sformatf("%s c_data[%0d]", tag, n), q_wd[n], sat(s));
               end
               n++;
            end
         end
         chk({tag, " a_addr sequence errors"}, bad_a, 0);
         chk({tag, " b_addr sequence errors"}, bad_b, 0);
      end else begin
         chk({tag, " err latency"}, err_cyc - start_cyc, 2);
         chk({tag, " no done"}, done_cyc, -1);
         chk({tag, " no reads"}, q_ra.size(), 0);
         chk({tag, " no writes"}, q_wa.size(), 0);
      end
      chk({tag, " strobes exclusive"}, multi_hi, 0);
   endtask

   task automatic load_2x2();
      mem_a[0] = -3; mem_a[1] = -15; mem_a[2] = -6; mem_a[3] = 7;
      mem_b[0] = 9;  mem_b[1] = -15; mem_b[2] = -2; mem_b[3] = -5;
   endtask

   task automatic check_2x2_consts(input string tag);
      int exp_d [4];
      exp_d = '{3, 120, -68, 55};
      chk({tag, " const count"}, q_wd.size(), 4);
      for (int n = 0; n < 4; n++)
         if (n < q_wd.size()) chk($sformatf("%s const[%0d]", tag, n), q_wd[n], exp_d[n]);
   endtask

   initial begin
      int ha, wa, hb, wb;
      wb_rst_i = 1'b1; start_i = 1'b0; op_i = '0;
      w_a_i = '0; h_a_i = '0; w_b_i = '0; h_b_i = '0;
      a_data_i = '0; b_data_i = '0;
      tick(); tick();
      check_outputs_zero("reset");
      wb_rst_i = 1'b0;
      tick();

      load_2x2();
      run_mm("mm2x2", 1, 2, 2, 2, 2, 0);
      check_2x2_consts("mm2x2");

      mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
      mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
      run_mm("nonsquare", 1, 1, 3, 3, 1, 0);
      if (q_wd.size() > 0) chk("nonsquare value", q_wd[0], 32);

      run_mm("mismatch", 1, 2, 2, 3, 2, 0);
      run_mm("bad op", 2, 2, 2, 2, 2, 0);
      run_mm("zero dim", 1, 0, 2, 2, 2, 0);
      run_mm("dim 17", 1, 17, 2, 2, 2, 0);

      mem_a[0] = 32767; mem_a[1] = 32767; mem_b[0] = 32767; mem_b[1] = 32767;
      run_mm("sat pos", 1, 1, 2, 2, 1, 0);
      if (q_wd.size() > 0) chk("sat pos value", q_wd[0], 32767);
      mem_a[0] = -32768; mem_a[1] = -32768;
      run_mm("sat neg", 1, 1, 2, 2, 1, 0);
      if (q_wd.size() > 0) chk("sat neg value", q_wd[0], -32768);

      load_2x2();
      run_mm("restart ignored", 1, 2, 2, 2, 2, 3);
      check_2x2_consts("restart ignored");

      // Reset in the middle of the first element's fetch.
      clear_logs();
      op_i = 8'd1; h_a_i = 5'd2; w_a_i = 5'd2; h_b_i = 5'd2; w_b_i = 5'd2;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick(); tick();
      chk("pre-reset in fetch", rd_en_o, 1);
      wb_rst_i = 1'b1;
      tick();
      check_outputs_zero("mid reset");
      wb_rst_i = 1'b0;
      clear_logs();
      for (int n = 0; n < 40; n++) tick();
      chk("abandoned no done", done_cyc, -1);
      chk("abandoned no writes", q_wa.size(), 0);
      run_mm("after reset", 1, 2, 2, 2, 2, 0);
      check_2x2_consts("after reset");

      fill(16, 16, 16, 1'b1);
      run_mm("max 16x16", 1, 16, 16, 16, 16, 0);

      for (int r = 0; r < 12; r++) begin
         ha = int'($urandom_range(1, 5));
         wa = int'($urandom_range(1, 5));
         wb = int'($urandom_range(1, 5));
         hb = ($urandom_range(4) == 0) ? int'($urandom_range(0, 6)) : wa;
         fill(ha, wa, wb, r[0]);
         run_mm($sformatf("rand%0d", r), 1, ha, wa, hb, wb, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
